nibble_serial_tx: RTL
=====================

# nibble_serial_tx

Parallel-in, serial-out transmitter that drains a WIDTH-bit word from an upstream enabled-register stage and sends it on a single wire. Frame format: start bit (0), data LSB first, stop bit (1). It sits at the consuming end of the register stage. Upstream presents a word with `load`; this block accepts it only when `ready` is high, then serializes it at a fixed clocks-per-bit rate.

## Interface
- `WIDTH`, default 4: data word width, ≥1.
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit, ≥1.
- `clk` input 1: clock, rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `load` input 1: upstream word valid; accepted when `load && ready` at a rising edge.
- `d` input WIDTH: word to transmit; sampled only on acceptance.
- `ready` output 1: block is idle and can accept a word.
- `busy` output 1: frame in progress; always equals `!ready`.
- `tx` output 1: serial line; idles high.
- `done` output 1: one-cycle pulse marking frame completion.

## Operation
- FSM states, with transitions:
  - IDLE → START on acceptance.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after WIDTH bits.
  - STOP → IDLE after CLKS_PER_BIT cycles.
- On acceptance:
  - `d` is captured into a WIDTH-bit shift register.
  - The bit timer and bit index are cleared.
- Line level by state:
  - START: `tx` = 0.
  - DATA: `tx` = shift[0]; the register shifts right once per completed bit period. Bit index counts 0..WIDTH-1.
  - STOP and IDLE: `tx` = 1.
- `ready` = (state == IDLE). `busy` = !ready.
- `done` is registered. It is high for exactly one cycle, the first IDLE cycle after STOP completes.
- `load` while `!ready` is ignored. `d` changes mid-frame have no effect.
- Back-to-back frames:
  - `load` asserted in the `done` cycle is accepted.
  - The next start bit begins on the following cycle.
  - Minimum inter-frame idle-high gap is therefore 1 cycle.
- Reset:
  - Asynchronous. Takes effect immediately, including mid-frame.
  - Forces state = IDLE, `tx` = 1, `ready` = 1, `busy` = 0, `done` = 0, shift register = 0, timer = 0, bit index = 0.
  - An in-flight frame is dropped, not resumed.
- Widths:
  - Bit timer is $clog2(CLKS_PER_BIT) bits, with a minimum of 1.
  - Bit index is $clog2(WIDTH) bits, with a minimum of 1.
  - The timer wraps from CLKS_PER_BIT-1 to 0, and that wrap is the bit-period tick.

## Timing
- Acceptance at edge N: `tx` falls to 0 after edge N, i.e. the start bit occupies cycles N+1..N+CLKS_PER_BIT.
- Data bit k occupies cycles N+1+(k+1)·CLKS_PER_BIT .. N+(k+2)·CLKS_PER_BIT.
- Stop bit occupies the final CLKS_PER_BIT cycles of the frame.
- Frame length is (WIDTH+2)·CLKS_PER_BIT cycles.
- `done` and `ready` rise together in cycle N+1+(WIDTH+2)·CLKS_PER_BIT.
- `tx` is driven from a flop, with no combinational path from `d`/`load` to `tx`.
- `ready` is decoded from the state register only.

## Structure
- Package `serial_tx_pkg` holds:
  - state typedef `tx_state_t` {IDLE, START, DATA, STOP}.
  - constants `START_BIT` = 1'b0 and `STOP_BIT` = 1'b1.
- One sub-module, `bit_timer`:
  - parameterized CLKS_PER_BIT.
  - inputs `clk`, `reset`, `clear`; output `tick`, high on the last cycle of each bit period.
- Top level contains the FSM, shift register, and bit index.

## Test plan
- Reset then idle, WIDTH=4, CLKS_PER_BIT=2: assert reset at t=5ns, release at 8ns → `tx`=1, `ready`=1, `busy`=0, `done`=0 immediately. Outputs stay there for 10 cycles with `load`=0.
- Single frame, `d`=4'b1011, CLKS_PER_BIT=2 → `tx` per 2-cycle slot is 0,1,1,0,1,1. `done` pulses once at cycle N+13. `ready` is low for cycles N+1..N+12.
- Ignored load: `load`=1 with `d`=4'b0000 during the frame above → transmitted bits unchanged (1,1,0,1).
- Back-to-back: `load` held high with `d`=4'b0101 then 4'b1110 → frames 0,1,0,1,0,1 and 0,0,1,1,1,1, separated by exactly one idle-high cycle (the `done` cycle).
- Reset mid-frame: assert reset during data bit 2 → `tx`=1 and `ready`=1 asynchronously, with no `done` pulse. The next `load` with `d`=4'b0011 transmits a complete correct frame.
- Parameter sweep: WIDTH=8, CLKS_PER_BIT=1, `d`=8'hA5 → `tx` = 0,1,0,1,0,0,1,0,1,1 on consecutive cycles.

Source files
------------

// File: rtl/nibble_serial_tx_pkg.sv
// Shared types and constants for the serial transmitter and its bit timer.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int counter_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serial_tx_bit_timer.sv
// Free-running bit-period counter; tick marks the last cycle of each period.
module bit_timer
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int               TW   = counter_width(CLKS_PER_BIT);
  localparam logic [TW-1:0]    LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nibble_serial_tx.sv
// Parallel-in serial-out transmitter: start bit, WIDTH data bits LSB first, stop bit.
module nibble_serial_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic             ready,
  output logic             busy,
  output logic             tx,
  output logic             done
);

  localparam int            IW       = counter_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             tick;

  // Holding the timer clear while idle guarantees a fresh period at acceptance.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(state_q == IDLE),
    .tick (tick)
  );

  assign ready = (state_q == IDLE);
  assign busy  = !ready;
  assign tx    = tx_q;
  assign done  = done_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = START;
          shift_d = d;
          idx_d   = '0;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so tx comes straight off a flop.
    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[0];
      default: tx_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= STOP_BIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule
